// File: rtl/get_reg_pkg.sv
// Shared constants and ABI name table for the integer register-name lookup.
// Used by the lookup ROM and by the FSM/output stage.
package get_reg_pkg;

  localparam int NREGS = 32;
  localparam int IDX_W = 6;
  localparam int STR_W = 32;

  typedef logic [STR_W-1:0] reg_name_t;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DUMP = 1'b1;

  localparam reg_name_t INV_NAME = "inv";

  localparam reg_name_t NAMES [NREGS] = '{
    "zero", "ra",  "sp",  "gp",
    "tp",   "t0",  "t1",  "t2",
    "s0",   "s1",  "a0",  "a1",
    "a2",   "a3",  "a4",  "a5",
    "a6",   "a7",  "s2",  "s3",
    "s4",   "s5",  "s6",  "s7",
    "s8",   "s9",  "s10", "s11",
    "t3",   "t4",  "t5",  "t6"
  };

  function automatic logic idx_bad(
    input logic [IDX_W-1:0] idx
  );
    return idx >= IDX_W'(NREGS);
  endfunction

  function automatic reg_name_t abi_name(
    input logic [IDX_W-1:0] idx
  );
    if (idx_bad(idx))
      return INV_NAME;
    return NAMES[idx[4:0]];
  endfunction

endpackage

// File: rtl/get_reg_rom.sv
// Combinational index -> ABI name lookup.
// Shared by the request path and the dump path.
module get_reg_rom
  import get_reg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output reg_name_t        name,
  output logic             err
);

  assign name = abi_name(idx);
  assign err  = idx_bad(idx);

endmodule

// File: rtl/get_reg.sv
// Register-name lookup for trace output: single requests plus
// a 32-beat streaming dump of every ABI name.
module get_reg
  import get_reg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             dump_start,
  output logic             busy,
  output logic             name_valid,
  output logic [IDX_W-1:0] name_idx,
  output reg_name_t        name_str,
  output logic             name_err,
  output logic             dump_last
);

  logic [0:0]       state;
  logic [4:0]       cnt;
  logic [IDX_W-1:0] rom_idx;
  reg_name_t        rom_name;
  logic             rom_err;

  // The dump counter owns the ROM while streaming.
  assign rom_idx = (state == DUMP) ? {1'b0, cnt} : req_idx;

  get_reg_rom u_rom (
    .idx  (rom_idx),
    .name (rom_name),
    .err  (rom_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      name_valid <= 1'b0;
      name_idx   <= '0;
      name_str   <= '0;
      name_err   <= 1'b0;
      dump_last  <= 1'b0;
    end else begin
      name_valid <= 1'b0;
      dump_last  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dump_start) begin
            state <= DUMP;
            cnt   <= '0;
            busy  <= 1'b1;
          end else if (req_valid) begin
            name_valid <= 1'b1;
            name_idx   <= req_idx;
            name_str   <= rom_name;
            name_err   <= rom_err;
          end
        end
        DUMP: begin
          name_valid <= 1'b1;
          name_idx   <= rom_idx;
          name_str   <= rom_name;
          name_err   <= 1'b0;
          if (cnt == 5'd31) begin
            dump_last <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_get_reg.sv
// Directed bench for get_reg: reset, lookups, invalid index,
// dump streaming, request-during-dump and dump-vs-request priority.
module tb_get_reg;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [5:0]  req_idx;
  logic        dump_start;
  logic        busy;
  logic        name_valid;
  logic [5:0]  name_idx;
  logic [31:0] name_str;
  logic        name_err;
  logic        dump_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_names [32] = '{
    "zero", "ra",  "sp",  "gp",
    "tp",   "t0",  "t1",  "t2",
    "s0",   "s1",  "a0",  "a1",
    "a2",   "a3",  "a4",  "a5",
    "a6",   "a7",  "s2",  "s3",
    "s4",   "s5",  "s6",  "s7",
    "s8",   "s9",  "s10", "s11",
    "t3",   "t4",  "t5",  "t6"
  };

  get_reg dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .dump_start (dump_start),
    .busy       (busy),
    .name_valid (name_valid),
    .name_idx   (name_idx),
    .name_str   (name_str),
    .name_err   (name_err),
    .dump_last  (dump_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    req_idx = '0;
    dump_start = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busy, name_valid, name_idx, name_str, name_err, dump_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b v=%b idx=%0d str=%h err=%b last=%b, want all 0",
               busy, name_valid, name_idx, name_str, name_err, dump_last);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (name_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b busy=%b, want 0 0", name_valid, busy);
    end
  endtask

  task automatic test_requests();
    logic [5:0]  idxs [4] = '{6'd0, 6'd1, 6'd10, 6'd31};
    logic [31:0] strs [4] = '{32'h7A65726F, 32'h00007261, 32'h00006130, 32'h00007436};
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_idx = idxs[i];
      tick();
      n_checks++;
      if (name_valid !== 1'b1 || name_idx !== idxs[i] ||
          name_str !== strs[i] || name_err !== 1'b0) begin
        n_fail++;
        $display("FAIL req_%0d: got v=%b idx=%0d str=%h err=%b, want v=1 idx=%0d str=%h err=0",
                 idxs[i], name_valid, name_idx, name_str, name_err, idxs[i], strs[i]);
      end
    end
    req_valid = 1'b0;
    req_idx = 6'd3;
    tick();
    n_checks++;
    if (name_valid !== 1'b0 || name_idx !== 6'd31 || name_str !== 32'h00007436) begin
      n_fail++;
      $display("FAIL req_hold: got v=%b idx=%0d str=%h, want v=0 idx=31 str=00007436",
               name_valid, name_idx, name_str);
    end
  endtask

  task automatic test_invalid();
    req_valid = 1'b1;
    req_idx = 6'd40;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (name_valid !== 1'b1 || name_idx !== 6'd40 ||
        name_str !== 32'h00696E76 || name_err !== 1'b1) begin
      n_fail++;
      $display("FAIL req_40: got v=%b idx=%0d str=%h err=%b, want v=1 idx=40 str=00696e76 err=1",
               name_valid, name_idx, name_str, name_err);
    end
    req_valid = 1'b1;
    req_idx = 6'd2;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (name_str !== 32'h00007370 || name_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got str=%h err=%b, want str=00007370 err=0",
               name_str, name_err);
    end
    tick();
  endtask

  task automatic test_dump();
    int bad = 0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || name_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_enter: got busy=%b v=%b, want busy=1 v=0", busy, name_valid);
    end
    for (int i = 0; i < 32; i++) begin
      tick();
      n_checks++;
      if (name_valid !== 1'b1 || name_idx !== 6'(i) || name_str !== exp_names[i] ||
          name_err !== 1'b0 || dump_last !== (i == 31)) begin
        n_fail++;
        bad++;
        $display("FAIL dump_beat_%0d: got v=%b idx=%0d str=%h err=%b last=%b, want v=1 idx=%0d str=%h err=0 last=%b",
                 i, name_valid, name_idx, name_str, name_err, dump_last,
                 i, exp_names[i], i == 31);
      end
      if (i < 31) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL dump_busy_%0d: got busy=%b, want 1", i, busy);
        end
      end
      if (bad > 3) break;
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || name_valid !== 1'b0 || dump_last !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_exit: got busy=%b v=%b last=%b, want 0 0 0",
               busy, name_valid, dump_last);
    end
  endtask

  task automatic test_req_during_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 3) begin
        req_valid = 1'b1;
        req_idx = 6'd5;
      end
      if (i == 10) dump_start = 1'b1;
      if (i == 11) dump_start = 1'b0;
      tick();
      n_checks++;
      if (name_valid !== 1'b1 || name_idx !== 6'(i) || name_str !== exp_names[i]) begin
        n_fail++;
        $display("FAIL busy_req_beat_%0d: got v=%b idx=%0d str=%h, want v=1 idx=%0d str=%h",
                 i, name_valid, name_idx, name_str, i, exp_names[i]);
      end
    end
    req_valid = 1'b0;
    tick();
    n_checks++;
    if (name_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_req_dropped: got v=%b busy=%b idx=%0d, want v=0 busy=0",
               name_valid, busy, name_idx);
    end
  endtask

  task automatic test_dump_wins();
    req_valid = 1'b1;
    req_idx = 6'd9;
    dump_start = 1'b1;
    tick();
    req_valid = 1'b0;
    dump_start = 1'b0;
    n_checks++;
    if (name_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_drop: got v=%b busy=%b idx=%0d, want v=0 busy=1",
               name_valid, busy, name_idx);
    end
    tick();
    n_checks++;
    if (name_valid !== 1'b1 || name_idx !== 6'd0 || name_str !== 32'h7A65726F) begin
      n_fail++;
      $display("FAIL collide_first: got v=%b idx=%0d str=%h, want v=1 idx=0 str=7a65726f",
               name_valid, name_idx, name_str);
    end
    for (int i = 1; i < 32; i++) tick();
    n_checks++;
    if (dump_last !== 1'b1 || name_idx !== 6'd31) begin
      n_fail++;
      $display("FAIL collide_last: got last=%b idx=%0d, want last=1 idx=31",
               dump_last, name_idx);
    end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    int seen = 0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, name_valid, name_idx, name_str, name_err, dump_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_dump: got busy=%b v=%b idx=%0d str=%h err=%b last=%b, want all 0",
               busy, name_valid, name_idx, name_str, name_err, dump_last);
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (name_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d active cycles after reset, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_requests();
    test_invalid();
    test_dump();
    test_req_during_dump();
    test_dump_wins();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
